// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: the redirect input, the instruction SRAM port and the decode handshake.
// The fetch unit connects through the master modport and its environment through the slave modport.
interface fetch_unit_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned INST_W = 32
);
  logic              redirect_i;
  logic [ADDR_W-1:0] redirect_pc_i;
  logic              inst_sram_en;
  logic [ADDR_W-1:0] inst_sram_addr;
  logic [INST_W-1:0] inst_sram_rdata;
  logic              if_valid_o;
  logic              if_ready_i;
  logic [INST_W-1:0] if_inst_o;
  logic [ADDR_W-1:0] if_pc_o;

  modport master (
    input  redirect_i, redirect_pc_i, inst_sram_rdata, if_ready_i,
    output inst_sram_en, inst_sram_addr, if_valid_o, if_inst_o, if_pc_o
  );

  modport slave (
    output redirect_i, redirect_pc_i, inst_sram_rdata, if_ready_i,
    input  inst_sram_en, inst_sram_addr, if_valid_o, if_inst_o, if_pc_o
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: sequential PC generation, 1-cycle-latency SRAM reads, and a PC-tagged
// FIFO toward decode, with credit-based backpressure and redirect flush.
module fetch_unit #(
  parameter int unsigned       ADDR_W    = 32,
  parameter int unsigned       INST_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter int unsigned       BUF_DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  fetch_unit_if.master bus
);
  localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);
  localparam int unsigned PTR_W = $clog2(BUF_DEPTH);

  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] tag_pc;
  logic              inflight;
  logic [CNT_W-1:0]  count;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [INST_W-1:0] inst_mem [BUF_DEPTH];
  logic [ADDR_W-1:0] pc_mem   [BUF_DEPTH];

  logic             pop;
  logic             push;
  logic             req;
  logic [CNT_W:0]   credit;

  assign bus.if_valid_o = ~rst & (count != '0);
  assign pop            = bus.if_valid_o & bus.if_ready_i;

  // Occupancy plus the response still in flight, less what decode takes this cycle; a new request
  // is only issued when its response is guaranteed a free slot.
  assign credit = {1'b0, count} + (CNT_W+1)'(inflight) - (CNT_W+1)'(pop);
  assign req    = ~rst & ~bus.redirect_i & (credit < (CNT_W+1)'(BUF_DEPTH));
  assign push   = inflight & ~bus.redirect_i;

  assign bus.inst_sram_en   = req;
  assign bus.inst_sram_addr = fetch_pc;
  assign bus.if_inst_o      = inst_mem[rd_ptr];
  assign bus.if_pc_o        = pc_mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      tag_pc   <= RESET_PC;
      inflight <= 1'b0;
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else if (bus.redirect_i) begin
      fetch_pc <= {bus.redirect_pc_i[ADDR_W-1:2], 2'b00};
      inflight <= 1'b0;
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else begin
      inflight <= req;
      if (req) begin
        fetch_pc <= fetch_pc + ADDR_W'(4);
        tag_pc   <= fetch_pc;
      end
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // NOTE: the FIFO storage has no reset; count gates every read, so stale contents are never seen.
  always_ff @(posedge clk) begin
    if (~rst && push) begin
      inst_mem[wr_ptr] <= bus.inst_sram_rdata;
      pc_mem[wr_ptr]   <= tag_pc;
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset, streaming, stall, redirect, wrap, mid-stream reset and a
// random soak, all checked against a reference PC sequence and a synthetic SRAM content function.
module tb_fetch_unit;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_unit_if bus ();
  fetch_unit_if w_bus ();

  fetch_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut_w (
    .clk (clk),
    .rst (rst),
    .bus (w_bus.master)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  always @(posedge clk) begin
    if (bus.inst_sram_en) bus.inst_sram_rdata <= mem_word(bus.inst_sram_addr);
    if (w_bus.inst_sram_en) w_bus.inst_sram_rdata <= mem_word(w_bus.inst_sram_addr);
  end

  int passed = 0;
  int failed = 0;
  int total  = 0;
  int pops   = 0;

  logic [31:0] exp_pc;
  logic [31:0] req_pc;
  logic        s_valid;
  logic        s_en;
  logic [31:0] s_addr;
  logic [31:0] s_pc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs at the falling edge, sample outputs 1ns later, and check every
  // accepted instruction and every issued address against the reference PC sequence.
  task automatic cycle(input logic rdy, input logic rd, input logic [31:0] rpc, input logic rs);
    @(negedge clk);
    rst               = rs;
    bus.if_ready_i    = rdy;
    bus.redirect_i    = rd;
    bus.redirect_pc_i = rpc;
    #1;
    s_valid = bus.if_valid_o;
    s_en    = bus.inst_sram_en;
    s_addr  = bus.inst_sram_addr;
    s_pc    = bus.if_pc_o;
    if (rs) begin
      check("rst_en", 32'(s_en), 32'd0);
      check("rst_valid", 32'(s_valid), 32'd0);
      exp_pc = 32'h0;
      req_pc = 32'h0;
    end else begin
      if (s_valid && rdy) begin
        check("pop_pc", s_pc, exp_pc);
        check("pop_inst", bus.if_inst_o, mem_word(exp_pc));
        exp_pc = exp_pc + 32'd4;
        pops++;
      end
      if (rd) begin
        check("redirect_en", 32'(s_en), 32'd0);
        exp_pc = {rpc[31:2], 2'b00};
        req_pc = {rpc[31:2], 2'b00};
      end else if (s_en) begin
        check("req_addr", s_addr, req_pc);
        req_pc = req_pc + 32'd4;
      end
    end
  endtask

  initial begin
    rst                 = 1'b1;
    bus.if_ready_i      = 1'b1;
    bus.redirect_i      = 1'b0;
    bus.redirect_pc_i   = '0;
    w_bus.if_ready_i    = 1'b1;
    w_bus.redirect_i    = 1'b0;
    w_bus.redirect_pc_i = '0;
    exp_pc              = 32'h0;
    req_pc              = 32'h0;

    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 32'h0, 1'b1);

    // Release: request at 0 right away, first instruction visible two cycles later.
    cycle(1'b1, 1'b0, 32'h0, 1'b0);
    check("c0_en", 32'(s_en), 32'd1);
    check("c0_addr", s_addr, 32'h0);
    check("c0_valid", 32'(s_valid), 32'd0);
    cycle(1'b1, 1'b0, 32'h0, 1'b0);
    check("c1_addr", s_addr, 32'h4);
    check("c1_valid", 32'(s_valid), 32'd0);
    cycle(1'b1, 1'b0, 32'h0, 1'b0);
    check("c2_valid", 32'(s_valid), 32'd1);
    check("c2_pc", s_pc, 32'h0);
    check("wrap_pc0", w_bus.if_pc_o, 32'hFFFF_FFF8);
    check("wrap_inst0", w_bus.if_inst_o, mem_word(32'hFFFF_FFF8));
    cycle(1'b1, 1'b0, 32'h0, 1'b0);
    check("wrap_pc1", w_bus.if_pc_o, 32'hFFFF_FFFC);
    cycle(1'b1, 1'b0, 32'h0, 1'b0);
    check("wrap_valid2", 32'(w_bus.if_valid_o), 32'd1);
    check("wrap_pc2", w_bus.if_pc_o, 32'h0000_0000);
    check("wrap_inst2", w_bus.if_inst_o, mem_word(32'h0));
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b0, 32'h0, 1'b0);
      check("stream_valid", 32'(s_valid), 32'd1);
    end

    // Stall: the buffer plus the in-flight slot is already at capacity, so requests stop at once.
    for (int i = 0; i < 6; i++) begin
      cycle(1'b0, 1'b0, 32'h0, 1'b0);
      check("stall_en", 32'(s_en), 32'd0);
      check("stall_valid", 32'(s_valid), 32'd1);
    end
    cycle(1'b1, 1'b0, 32'h0, 1'b0);
    check("resume_en", 32'(s_en), 32'd1);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 1'b0, 32'h0, 1'b0);
      check("resume_valid", 32'(s_valid), 32'd1);
    end

    // Fill the FIFO, then redirect to 0x103 (low bits forced to zero).
    cycle(1'b0, 1'b0, 32'h0, 1'b0);
    cycle(1'b0, 1'b0, 32'h0, 1'b0);
    check("full_en", 32'(s_en), 32'd0);
    cycle(1'b0, 1'b1, 32'h103, 1'b0);
    cycle(1'b1, 1'b0, 32'h0, 1'b0);
    check("flush_valid", 32'(s_valid), 32'd0);
    check("flush_en", 32'(s_en), 32'd1);
    check("flush_addr", s_addr, 32'h100);
    cycle(1'b1, 1'b0, 32'h0, 1'b0);
    check("flush_valid2", 32'(s_valid), 32'd0);
    cycle(1'b1, 1'b0, 32'h0, 1'b0);
    check("target_valid", 32'(s_valid), 32'd1);
    check("target_pc", s_pc, 32'h100);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 32'h0, 1'b0);

    // Pop and redirect in the same cycle while a response is in flight.
    cycle(1'b1, 1'b1, 32'h200, 1'b0);
    check("popredir_valid", 32'(s_valid), 32'd1);
    cycle(1'b1, 1'b0, 32'h0, 1'b0);
    check("popredir_valid1", 32'(s_valid), 32'd0);
    check("popredir_addr", s_addr, 32'h200);
    cycle(1'b1, 1'b0, 32'h0, 1'b0);
    check("popredir_valid2", 32'(s_valid), 32'd0);
    cycle(1'b1, 1'b0, 32'h0, 1'b0);
    check("popredir_pc", s_pc, 32'h200);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 32'h0, 1'b0);

    // Reset mid-stream with a response in flight: no ghost instruction, restart at the reset PC.
    cycle(1'b1, 1'b0, 32'h0, 1'b1);
    cycle(1'b1, 1'b0, 32'h0, 1'b0);
    check("rerst_valid0", 32'(s_valid), 32'd0);
    check("rerst_addr", s_addr, 32'h0);
    cycle(1'b1, 1'b0, 32'h0, 1'b0);
    check("rerst_valid1", 32'(s_valid), 32'd0);
    cycle(1'b1, 1'b0, 32'h0, 1'b0);
    check("rerst_valid2", 32'(s_valid), 32'd1);
    check("rerst_pc", s_pc, 32'h0);

    // Random soak: sparse redirects to arbitrary targets, ready asserted about 3 cycles in 4.
    pops = 0;
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0), $urandom, 1'b0);
    end
    check("soak_progress", 32'(pops > 100), 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
